// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
// Signed operation is selected by defining DIV_SIGNED_EN.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    // Two's complement negation, used for magnitude and sign fix-up.
    function automatic logic [DIV_WIDTH-1:0] neg2(input logic [DIV_WIDTH-1:0] v);
        return (~v) + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/sub_33_bit.sv
// Combinational 33-bit subtractor: a - b as a + ~b + 1.
// borrow is high when b > a (unsigned), i.e. the result is negative.
module sub_33_bit (
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [32:0] diff,
    output logic        borrow
);

    logic carry;

    // Add the inverted subtrahend with carry-in 1; carry-out clear means borrow.
    always_comb begin
        {carry, diff} = {1'b0, a} + {1'b0, ~b} + 34'd1;
        borrow = ~carry;
    end

endmodule

// File: rtl/div_32_seq.sv
// Restoring divider: one quotient bit per clock, quotient to lo, remainder to hi.
// Define DIV_SIGNED_EN for two's complement operands (truncation toward zero).
module div_32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_zero
);

    state_t               state;
    state_t               state_nx;
    logic [DIV_CNT_W-1:0] cnt;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     dvs;
    logic                 zero;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     fix_lo;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH:0]       diff;
    logic                 borrow;
    logic                 b_zero;

    // The difference is always below the divisor when kept, so its MSB is spare.
    logic unused_diff_msb;
    assign unused_diff_msb = diff[WIDTH];

    assign b_zero = (Rb == '0);
    assign busy   = (state != IDLE);

    sub_33_bit u_sub (
        .a      ({rem, quo[WIDTH-1]}),
        .b      ({1'b0, dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Operands become magnitudes; results get their signs back in FIX.
    always_comb begin
        mag_a  = Ra[WIDTH-1] ? neg2(Ra) : Ra;
        mag_b  = Rb[WIDTH-1] ? neg2(Rb) : Rb;
        fix_lo = neg_q ? neg2(quo) : quo;
        fix_hi = neg_r ? neg2(rem) : rem;
    end

    // Remember the result signs at accept time.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= Ra[WIDTH-1] ^ Rb[WIDTH-1];
            neg_r <= Ra[WIDTH-1];
        end
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        mag_a  = Ra;
        mag_b  = Rb;
        fix_lo = quo;
        fix_hi = rem;
    end
`endif

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a zero divisor skips straight to FIX.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = b_zero ? FIX : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nx = FIX;
                end
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture, shift/trial-subtract, and result load.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            zero     <= 1'b0;
            done     <= 1'b0;
            lo       <= '0;
            hi       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '1;
                        rem  <= '0;
                        dvs  <= mag_b;
                        zero <= b_zero;
                        quo  <= b_zero ? Ra : mag_a;
                    end
                end
                RUN: begin
                    quo <= {quo[WIDTH-2:0], ~borrow};
                    rem <= borrow ? {rem[WIDTH-2:0], quo[WIDTH-1]}
                                  : diff[WIDTH-1:0];
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= zero;
                    lo       <= zero ? DIV_ZERO_QUO : fix_lo;
                    hi       <= zero ? quo : fix_hi;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: vector table, scoreboard, corner sequences.
// Signed vectors are selected when DIV_SIGNED_EN is defined.
module tb_div_32_seq;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        div_zero;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sq[$];
    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    div_32_seq dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .start    (start),
        .Ra       (Ra),
        .Rb       (Rb),
        .busy     (busy),
        .done     (done),
        .lo       (lo),
        .hi       (hi),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] q, input logic [31:0] r,
                                input logic dz);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.lo  = q;
        v.hi  = r;
        v.dz  = dz;
        v.lat = dz ? 1 : 33;
        return v;
    endfunction

    // Scoreboard consumer: compare every done against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (sq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sq.pop_front();
                check("lo", lo, e.lo);
                check("hi", hi, e.hi);
                check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                check("latency", cyc - e.acc, e.lat);
                check("busy_cycles", busy_cnt, e.lat);
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
            busy_cnt = 0;
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r,
                          input logic dz, input int lat);
        exp_t e;
        @(negedge clock);
        Ra    = a;
        Rb    = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        e.lo  = q;
        e.hi  = r;
        e.dz  = dz;
        e.lat = lat;
        e.acc = cyc;
        sq.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sq.size() != 0; i++) @(negedge clock);
        if (sq.size() != 0) begin
            check("done_timeout", sq.size(), 32'd0);
            sq.delete();
        end
    endtask

    task automatic run_op(input vec_t v);
        launch(v.a, v.b, v.lo, v.hi, v.dz, v.lat);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [31:0] a;
        logic [31:0] b;

        clear_n = 1'b0;
        start   = 1'b0;
        Ra      = '0;
        Rb      = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        clear_n = 1'b1;
        busy_cnt = 0;

        tbl.push_back(mk(32'd100, 32'd7, 32'd14, 32'd2, 1'b0));
        tbl.push_back(mk(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1));
        tbl.push_back(mk(32'd9, 32'd3, 32'd3, 32'd0, 1'b0));
        tbl.push_back(mk(32'd0, 32'd5, 32'd0, 32'd0, 1'b0));
        tbl.push_back(mk(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1));
`ifdef DIV_SIGNED_EN
        tbl.push_back(mk(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
        tbl.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0));
        tbl.push_back(mk(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0));
        tbl.push_back(mk(32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0));
        tbl.push_back(mk(32'd7, 32'd100, 32'd0, 32'd7, 1'b0));
`else
        tbl.push_back(mk(32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0));
        tbl.push_back(mk(32'd7, 32'd100, 32'd0, 32'd7, 1'b0));
        tbl.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0));
        tbl.push_back(mk(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0));
        tbl.push_back(mk(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0));
`endif
        for (int i = 0; i < tbl.size(); i++) run_op(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd1;
`ifdef DIV_SIGNED_EN
            if (a == 32'h8000_0000) a = 32'h8000_0001;
            launch(a, b, $signed(a) / $signed(b), $signed(a) % $signed(b), 1'b0, 33);
`else
            launch(a, b, a / b, a % b, 1'b0, 33);
`endif
            drain();
        end

        // A start pulse during RUN must be ignored; later operand changes too.
        d0 = done_cnt;
        launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        repeat (9) @(posedge clock);
        @(negedge clock);
        Ra    = 32'd50;
        Rb    = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        Ra    = 32'd0;
        Rb    = 32'd0;
        drain();
        repeat (40) @(negedge clock);
        check("ignored_start_done_count", done_cnt - d0, 32'd1);

        // Reset in the middle of RUN aborts with everything cleared.
        launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        repeat (16) @(posedge clock);
        #1;
        clear_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_dz", {31'd0, div_zero}, 32'd0);
        sq.delete();
        d0 = done_cnt;
        @(negedge clock);
        clear_n  = 1'b1;
        busy_cnt = 0;
        repeat (40) @(negedge clock);
        check("abort_no_done", done_cnt - d0, 32'd0);
        run_op(mk(32'd20, 32'd6, 32'd3, 32'd2, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_32_seq.md
# div_32_seq

Sequential 32-bit integer divider: the inverse companion of the datapath's 32-bit carry-lookahead adder, built on repeated trial subtraction. It sits beside the adder in the ALU and services DIV instructions. The quotient goes to LO and the remainder to HI. It uses a start/done handshake and takes one quotient bit per clock (restoring algorithm).

## Interface
- `WIDTH`, 32: operand, quotient and remainder width. Only 32 is supported.
- `clock` in 1: rising-edge clock.
- `clear_n` in 1: asynchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE.
- `Ra` in 32: dividend, captured when `start` is accepted.
- `Rb` in 32: divisor, captured when `start` is accepted.
- `busy` out 1: high from the accept edge until `done` rises.
- `done` out 1: one-cycle pulse; `lo`/`hi`/`div_zero` are valid from this cycle.
- `lo` out 32: quotient. Holds its value until the next `done`.
- `hi` out 32: remainder. Holds its value until the next `done`.
- `div_zero` out 1: `Rb` was 0 for the last completed operation. Holds until the next `done`.

## Operation
- States:
  - IDLE: `start`=1 → capture operands. Go to FIX if `Rb`==0, otherwise go to RUN with `cnt`=31.
  - RUN: each cycle, shift the {rem, quo} pair left by one and do a trial subtract rem−div (33-bit).
    - Non-negative result: keep the difference and set the new quotient LSB to 1.
    - Negative result: restore and set the LSB to 0.
    - `cnt`==0 → FIX; otherwise `cnt`−1.
  - FIX: apply sign correction (if configured), load `lo`/`hi`/`div_zero`, pulse `done`, go to IDLE.
- Arithmetic:
  - Magnitudes are divided as 32-bit unsigned values.
  - The trial subtract is 33 bits wide, so a dividend or divisor ≥ 2^31 never overflows.
- Divide by zero: `lo`=0xFFFFFFFF, `hi`=captured dividend, `div_zero`=1, and no RUN cycles.
- `start` while `busy`: ignored, with no queuing. `Ra`/`Rb` changes after capture have no effect.
- `start` held high in the `done` cycle: that cycle is IDLE-equivalent only after FIX. The next accept is the edge following the `done` cycle.
- Reset:
  - Outputs: `busy`=0, `done`=0, `lo`=0, `hi`=0, `div_zero`=0.
  - State IDLE, `cnt`=0, internal registers 0.
  - `clear_n` asserted mid-operation aborts immediately. No `done` is produced.

## Timing
- Define the accept edge as E0.
- Normal divide: RUN occupies E1..E32 and FIX occurs at E33.
  - `done`=1 for exactly the cycle between E33 and E34. Latency is 33 clocks from accept to `done`.
- Divide by zero: FIX at E1, `done` between E1 and E2. Latency is 1 clock.
- `busy` rises after E0 and falls after the FIX edge, at the same edge where `done` rises.
- Back-to-back: the earliest next accept is the edge ending the `done` cycle.

## Configuration
- `DIV_SIGNED_EN` defined: operands are two's complement.
  - Both operands are converted to magnitudes in IDLE.
  - In FIX, the quotient is negated if the signs differ, and the remainder takes the sign of the dividend.
  - This gives truncation toward zero.
  - 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, with no flag.
- `DIV_SIGNED_EN` undefined: purely unsigned; no sign logic is generated.
- Divide-by-zero results are identical in both modes.

## Structure
- Package `div_pkg`:
  - state enum {IDLE, RUN, FIX};
  - `DIV_WIDTH`=32;
  - `DIV_CNT_W`=5;
  - `DIV_ZERO_QUO`=32'hFFFFFFFF.
- Sub-module `sub_33_bit`: combinational 33-bit subtractor. It outputs the difference and a borrow/sign bit, and is built as an add with the inverted operand and carry-in 1.
- The FSM, counter and shift registers stay in `div_32_seq`.

## Test plan
- 100 / 7 → `lo`=14, `hi`=2, `div_zero`=0, `done` exactly 33 clocks after accept, `busy` high for 33 cycles.
- 0xFFFFFFFF / 0x10 (unsigned build) → `lo`=0x0FFFFFFF, `hi`=0xF.
- Signed build, −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- 5 / 0 → `done` 1 clock after accept, `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=1. A following 9/3 → `lo`=3, `hi`=0, `div_zero`=0.
- Pulse `start` with 50/5 at cycle 10 of a running 100/7 → ignored; the result is 14 r 2 and no second `done` occurs.
- Assert `clear_n`=0 at RUN cycle 16 → `busy`, `done`, `lo`, `hi` and `div_zero` all 0 immediately. After release, 20/6 → `lo`=3, `hi`=2.
